idelay_rst_sequencer: RTL and testbench
=======================================

Name: idelay_rst_sequencer

Overview:
Consumer side of the infrastructure block's clock-lock and IDELAYCTRL handshake.
- Watches sys_clk_lock and idelay_rdy.
- Drives idelay_rst back into the infrastructure block.
- Releases a clean user reset to fabric logic only after the clocks are stable and the IDELAYCTRL is calibrated.
- Sits beside the infrastructure instance in the base system. Handles lock loss, ready loss and calibration timeout with bounded retries.

Parameters:
- LOCK_STABLE_CYCLES, 1024: cycles lock must stay high before the IDELAYCTRL reset is issued.
- IDELAY_RST_CYCLES, 16: idelay_rst pulse width in cycles.
- RDY_TIMEOUT_CYCLES, 4096: cycles to wait for idelay_rdy before retrying.
- RELEASE_CYCLES, 64: cycles between ready and user_rst deassertion.
- MAX_RETRIES, 3: IDELAYCTRL reset retries before FAULT.
- CNT_W, 16: width of the shared phase counter. All cycle parameters must be ≤ 2^CNT_W; a parameter value of 0 is treated as 1.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  reset; asynchronous, active-high.
- sys_clk_lock  in  1  DCM/MMCM lock; asynchronous.
- idelay_rdy  in  1  IDELAYCTRL ready; asynchronous.
- soft_rst  in  1  synchronous one-cycle request to re-run the sequence.
- idelay_rst  out  1  IDELAYCTRL reset request.
- user_rst  out  1  fabric reset, active-high.
- seq_ready  out  1  high only in RUN.
- seq_state  out  3  current state encoding.
- retry_cnt  out  4  retries used in the current sequence.
- timeout_err  out  1  sticky calibration failure flag.

Behaviour:
- Reset values:
  - idelay_rst=1, user_rst=1, seq_ready=0.
  - seq_state=WAIT_LOCK(0), retry_cnt=0, timeout_err=0.
  - Reset takes effect immediately on sys_rst high, mid-operation included.
- Input synchronisation:
  - sys_clk_lock and idelay_rdy each pass through a 2-flop synchroniser, giving lock_s and rdy_s.
  - soft_rst is used directly.
- Outputs are registered and decoded from next-state, so they change on the same edge as seq_state.
  - Latency from an input edge to an output change is 3 sys_clk edges.
- States:
  - 0 WAIT_LOCK, 1 LOCK_STABLE, 2 IDLY_RST, 3 WAIT_RDY, 4 RELEASE, 5 RUN, 6 FAULT.
- Output decode:
  - idelay_rst=1 in WAIT_LOCK, LOCK_STABLE and IDLY_RST; 0 elsewhere.
  - user_rst=0 only in RUN.
  - seq_ready=1 only in RUN.
- Phase counter: a single CNT_W counter, cleared on every state change and incremented otherwise.
- Transitions, evaluated in priority order:
  1. lock_s=0 in any state except WAIT_LOCK or FAULT: go to WAIT_LOCK.
  2. soft_rst=1 in any state: go to WAIT_LOCK and clear retry_cnt.
  3. rdy_s=0 in RELEASE or RUN: go to IDLY_RST; retry_cnt unchanged.
  4. Per-state rules:
     - WAIT_LOCK: lock_s=1 goes to LOCK_STABLE.
     - LOCK_STABLE: cnt==LOCK_STABLE_CYCLES-1 goes to IDLY_RST.
     - IDLY_RST: cnt==IDELAY_RST_CYCLES-1 goes to WAIT_RDY.
     - WAIT_RDY, rdy_s=1: go to RELEASE. If rdy_s=1 and the timeout expire on the same cycle, rdy_s wins.
     - WAIT_RDY, cnt==RDY_TIMEOUT_CYCLES-1 with retry_cnt<MAX_RETRIES: increment retry_cnt and go to IDLY_RST.
     - WAIT_RDY, cnt==RDY_TIMEOUT_CYCLES-1 with retry_cnt==MAX_RETRIES: go to FAULT and set timeout_err=1.
     - RELEASE: cnt==RELEASE_CYCLES-1 goes to RUN.
     - FAULT: holds, ignores lock and rdy, and leaves only on soft_rst or sys_rst.
- timeout_err is cleared only by sys_rst.
- retry_cnt saturates at MAX_RETRIES and holds its value through RUN as a diagnostic.

Decomposition:
- Package idelay_rst_seq_pkg holds:
  - the state enum and its encodings (3 bits);
  - the SEQ_STATE_W=3 and RETRY_W=4 constants.
- Sub-module sync_2ff (1-bit, two flops, async reset to 0) is instantiated twice, for lock and rdy.

Test Plan:
Bench parameters: LOCK_STABLE_CYCLES=8, IDELAY_RST_CYCLES=4, RDY_TIMEOUT_CYCLES=16, RELEASE_CYCLES=4, MAX_RETRIES=2.
1. Normal bring-up: idelay_rdy held 1, lock rises at edge 0 -> LOCK_STABLE at edge 3, idelay_rst falls at edge 15, user_rst falls and seq_ready rises at edge 20.
2. idelay_rdy held 0 -> three idelay_rst pulses of 4 cycles each, then seq_state=6, timeout_err=1, retry_cnt=2; user_rst stays 1.
3. Lock drops for 3 cycles during LOCK_STABLE cycle 5 -> return to WAIT_LOCK, counter restarts, idelay_rst never deasserts.
4. In RUN, sys_clk_lock falls -> user_rst=1 and seq_ready=0 3 edges later, seq_state=0. In RUN, idelay_rdy falls instead -> seq_state=2, retry_cnt unchanged.
5. sys_rst pulsed asynchronously mid-WAIT_RDY -> all outputs at reset values before the next edge; the sequence restarts cleanly.
6. From FAULT, soft_rst pulse -> seq_state=0 and retry_cnt=0 next edge, timeout_err remains 1; bring-up then completes as in scenario 1.

Source files
------------

// File: rtl/idelay_rst_seq_pkg.sv
// Shared types and constants for the IDELAYCTRL reset sequencer.
// The terminal-count helper maps a zero-length phase onto one cycle.
package idelay_rst_seq_pkg;

  localparam int SEQ_STATE_W = 3;
  localparam int RETRY_W     = 4;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_WAIT_LOCK   = 3'd0,
    ST_LOCK_STABLE = 3'd1,
    ST_IDLY_RST    = 3'd2,
    ST_WAIT_RDY    = 3'd3,
    ST_RELEASE     = 3'd4,
    ST_RUN         = 3'd5,
    ST_FAULT       = 3'd6
  } seq_state_e;

  // Counter value on the last cycle of a phase lasting 'cycles' cycles.
  function automatic logic [31:0] last_cnt(input int unsigned cycles);
    return (cycles == 0) ? 32'd0 : 32'(cycles - 1);
  endfunction

endpackage

// File: rtl/idelay_rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Both stages clear to 0 so a lost input reads as "not ready" out of reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/idelay_rst_sequencer.sv
// Sequences clock lock -> IDELAYCTRL reset -> ready -> user reset release,
// with lock/ready loss recovery and bounded calibration retries.
module idelay_rst_sequencer
  import idelay_rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned IDELAY_RST_CYCLES  = 16,
  parameter int unsigned RDY_TIMEOUT_CYCLES = 4096,
  parameter int unsigned RELEASE_CYCLES     = 64,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int          CNT_W              = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sys_clk_lock,
  input  logic                   idelay_rdy,
  input  logic                   soft_rst,
  output logic                   idelay_rst,
  output logic                   user_rst,
  output logic                   seq_ready,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic [RETRY_W-1:0]     retry_cnt,
  output logic                   timeout_err
);

  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(last_cnt(LOCK_STABLE_CYCLES));
  localparam logic [CNT_W-1:0]   IRST_LAST = CNT_W'(last_cnt(IDELAY_RST_CYCLES));
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(last_cnt(RDY_TIMEOUT_CYCLES));
  localparam logic [CNT_W-1:0]   REL_LAST  = CNT_W'(last_cnt(RELEASE_CYCLES));
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic lock_s;
  logic rdy_s;

  sync_2ff u_sync_lock (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (sys_clk_lock),
    .q_o   (lock_s)
  );

  sync_2ff u_sync_rdy (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (idelay_rdy),
    .q_o   (rdy_s)
  );

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               terr_q, terr_d;
  logic               idelay_rst_q, user_rst_q, seq_ready_q;
  logic               idelay_rst_d, user_rst_d, seq_ready_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    terr_d  = terr_q;

    if (!lock_s && state_q != ST_WAIT_LOCK && state_q != ST_FAULT) begin
      state_d = ST_WAIT_LOCK;
    end else if (soft_rst) begin
      state_d = ST_WAIT_LOCK;
      retry_d = '0;
    end else if (!rdy_s && (state_q == ST_RELEASE || state_q == ST_RUN)) begin
      state_d = ST_IDLY_RST;
    end else begin
      case (state_q)
        ST_WAIT_LOCK:   if (lock_s) state_d = ST_LOCK_STABLE;
        ST_LOCK_STABLE: if (cnt_q == LOCK_LAST) state_d = ST_IDLY_RST;
        ST_IDLY_RST:    if (cnt_q == IRST_LAST) state_d = ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          // Ready arriving on the timeout cycle still counts as success.
          if (rdy_s) begin
            state_d = ST_RELEASE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_IDLY_RST;
            end else begin
              state_d = ST_FAULT;
              terr_d  = 1'b1;
            end
          end
        end
        ST_RELEASE:     if (cnt_q == REL_LAST) state_d = ST_RUN;
        ST_RUN:         ;
        ST_FAULT:       ;
        default:        state_d = ST_WAIT_LOCK;
      endcase
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    // Outputs follow the next state so they move on the same edge as seq_state.
    idelay_rst_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCK_STABLE) ||
                   (state_d == ST_IDLY_RST);
    user_rst_d   = (state_d != ST_RUN);
    seq_ready_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      retry_q      <= '0;
      terr_q       <= 1'b0;
      idelay_rst_q <= 1'b1;
      user_rst_q   <= 1'b1;
      seq_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      terr_q       <= terr_d;
      idelay_rst_q <= idelay_rst_d;
      user_rst_q   <= user_rst_d;
      seq_ready_q  <= seq_ready_d;
    end
  end

  assign idelay_rst  = idelay_rst_q;
  assign user_rst    = user_rst_q;
  assign seq_ready   = seq_ready_q;
  assign seq_state   = state_q;
  assign retry_cnt   = retry_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_idelay_rst_sequencer.sv
// Directed bench for idelay_rst_sequencer; edge numbers in comments count
// sys_clk rising edges from the step where the stimulus changed (E0).
module tb_idelay_rst_sequencer;
  import idelay_rst_seq_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst, sys_clk_lock, idelay_rdy, soft_rst;
  logic       idelay_rst, user_rst, seq_ready, timeout_err;
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;
  int         checks = 0;
  int         errors = 0;

  always #5 sys_clk = ~sys_clk;

  idelay_rst_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .IDELAY_RST_CYCLES  (4),
    .RDY_TIMEOUT_CYCLES (16),
    .RELEASE_CYCLES     (4),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sys_clk_lock (sys_clk_lock),
    .idelay_rdy   (idelay_rdy),
    .soft_rst     (soft_rst),
    .idelay_rst   (idelay_rst),
    .user_rst     (user_rst),
    .seq_ready    (seq_ready),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt),
    .timeout_err  (timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input seq_state_e st, input int rc, input logic te);
    logic ir, ur, sr;
    ir = (st == ST_WAIT_LOCK) || (st == ST_LOCK_STABLE) || (st == ST_IDLY_RST);
    ur = (st != ST_RUN);
    sr = (st == ST_RUN);
    checks++;
    assert (seq_state === 3'(st) && retry_cnt === 4'(rc) && timeout_err === te &&
            idelay_rst === ir && user_rst === ur && seq_ready === sr)
    else begin
      errors++;
      $error("FAIL %s: observed st=%0d rc=%0d te=%b irst=%b urst=%b rdy=%b, expected st=%0d rc=%0d te=%b irst=%b urst=%b rdy=%b",
             tag, seq_state, retry_cnt, timeout_err, idelay_rst, user_rst, seq_ready,
             3'(st), rc, te, ir, ur, sr);
    end
  endtask

  initial begin
    sys_rst = 1'b0; sys_clk_lock = 1'b0; idelay_rdy = 1'b1; soft_rst = 1'b0;
    #1 sys_rst = 1'b1;
    #1 chk("reset_values", ST_WAIT_LOCK, 0, 1'b0);
    tick(2); sys_rst = 1'b0;
    tick(3); chk("idle_no_lock", ST_WAIT_LOCK, 0, 1'b0);

    // Normal bring-up
    sys_clk_lock = 1'b1;                                  // E0
    tick(2);  chk("up_e2_still_wait", ST_WAIT_LOCK, 0, 1'b0);
    tick(1);  chk("up_e3_lock_stable", ST_LOCK_STABLE, 0, 1'b0);
    tick(11); chk("up_e14_idly_rst", ST_IDLY_RST, 0, 1'b0);
    tick(1);  chk("up_e15_irst_fall", ST_WAIT_RDY, 0, 1'b0);
    tick(1);  chk("up_e16_release", ST_RELEASE, 0, 1'b0);
    tick(3);  chk("up_e19_release", ST_RELEASE, 0, 1'b0);
    tick(1);  chk("up_e20_run", ST_RUN, 0, 1'b0);

    // Lock loss in RUN, then re-bring-up
    sys_clk_lock = 1'b0;                                  // E0
    tick(2);  chk("lockloss_e2_run", ST_RUN, 0, 1'b0);
    tick(1);  chk("lockloss_e3_wait", ST_WAIT_LOCK, 0, 1'b0);
    sys_clk_lock = 1'b1;
    tick(20); chk("relock_run", ST_RUN, 0, 1'b0);

    // Ready loss in RUN, ready stays low -> retries -> FAULT
    idelay_rdy = 1'b0;                                    // E0
    tick(2);  chk("rdyloss_e2_run", ST_RUN, 0, 1'b0);
    tick(1);  chk("rdyloss_e3_idly", ST_IDLY_RST, 0, 1'b0);
    tick(3);  chk("pulse1_e6", ST_IDLY_RST, 0, 1'b0);
    tick(1);  chk("pulse1_end_e7", ST_WAIT_RDY, 0, 1'b0);
    tick(15); chk("tmo1_e22", ST_WAIT_RDY, 0, 1'b0);
    tick(1);  chk("retry1_e23", ST_IDLY_RST, 1, 1'b0);
    tick(4);  chk("pulse2_end_e27", ST_WAIT_RDY, 1, 1'b0);
    tick(16); chk("retry2_e43", ST_IDLY_RST, 2, 1'b0);
    tick(4);  chk("pulse3_end_e47", ST_WAIT_RDY, 2, 1'b0);
    tick(15); chk("tmo3_e62", ST_WAIT_RDY, 2, 1'b0);
    tick(1);  chk("fault_e63", ST_FAULT, 2, 1'b1);
    sys_clk_lock = 1'b0;
    tick(6);  chk("fault_ignores_lock", ST_FAULT, 2, 1'b1);
    idelay_rdy = 1'b1; sys_clk_lock = 1'b1;
    tick(4);  chk("fault_ignores_rdy", ST_FAULT, 2, 1'b1);

    // soft_rst out of FAULT; timeout_err stays sticky
    soft_rst = 1'b1;                                      // E0
    tick(1);  soft_rst = 1'b0;
    chk("soft_e1_wait", ST_WAIT_LOCK, 0, 1'b1);
    tick(1);  chk("soft_e2_lock_stable", ST_LOCK_STABLE, 0, 1'b1);
    tick(16); chk("soft_e18_release", ST_RELEASE, 0, 1'b1);
    tick(1);  chk("soft_e19_run", ST_RUN, 0, 1'b1);

    // Lock glitch during LOCK_STABLE restarts the count
    sys_clk_lock = 1'b0;
    tick(3);  chk("glitch_prep_wait", ST_WAIT_LOCK, 0, 1'b1);
    tick(2);
    sys_clk_lock = 1'b1;                                  // E0
    tick(3);  chk("glitch_e3_ls", ST_LOCK_STABLE, 0, 1'b1);
    tick(2);  sys_clk_lock = 1'b0;                        // E5
    tick(2);  chk("glitch_e7_ls", ST_LOCK_STABLE, 0, 1'b1);
    tick(1);  chk("glitch_e8_wait", ST_WAIT_LOCK, 0, 1'b1);
    sys_clk_lock = 1'b1;                                  // E8
    tick(2);  chk("glitch_e10_wait", ST_WAIT_LOCK, 0, 1'b1);
    tick(1);  chk("glitch_e11_ls", ST_LOCK_STABLE, 0, 1'b1);
    tick(7);  chk("glitch_e18_ls", ST_LOCK_STABLE, 0, 1'b1);
    tick(1);  chk("glitch_e19_idly", ST_IDLY_RST, 0, 1'b1);
    tick(4);  chk("glitch_e23_wait_rdy", ST_WAIT_RDY, 0, 1'b1);
    tick(5);  chk("glitch_e28_run", ST_RUN, 0, 1'b1);

    // Async reset mid-WAIT_RDY after one retry
    idelay_rdy = 1'b0;                                    // E0
    tick(3);  chk("ar_e3_idly", ST_IDLY_RST, 0, 1'b1);
    tick(4);  chk("ar_e7_wait_rdy", ST_WAIT_RDY, 0, 1'b1);
    tick(16); chk("ar_e23_retry", ST_IDLY_RST, 1, 1'b1);
    tick(4);  chk("ar_e27_wait_rdy", ST_WAIT_RDY, 1, 1'b1);
    tick(2);
    #2 sys_rst = 1'b1;
    #1 chk("ar_immediate", ST_WAIT_LOCK, 0, 1'b0);
    idelay_rdy = 1'b1;
    tick(2);  chk("ar_held", ST_WAIT_LOCK, 0, 1'b0);
    sys_rst = 1'b0;                                       // E0
    tick(2);  chk("ar_rel_e2", ST_WAIT_LOCK, 0, 1'b0);
    tick(1);  chk("ar_rel_e3_ls", ST_LOCK_STABLE, 0, 1'b0);
    tick(17); chk("ar_rel_e20_run", ST_RUN, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
